ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

ID/EX pipeline register and operand-forwarding stage that sits directly upstream of the ALU. Each cycle it latches one decoded instruction from the decode stage. It resolves RAW hazards by forwarding results from the EX/MEM and MEM/WB stages, and drives the ALU's `AluOp`, `A` and `B` inputs. It also detects load-use hazards and inserts a one-cycle bubble.

## Interface
- `DATA_W`, 32, operand and result width
- `RA_W`, 5, register-address width

- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `stall`  in  1  global pipeline hold; the ID/EX register keeps its contents
- `flush`  in  1  replace the incoming instruction with a bubble (branch/jump redirect)
- `id_valid`  in  1  the decode stage holds a real instruction
- `id_alu_op`  in  4  ALU operation code, passed through to the ALU
- `id_rs_addr`, `id_rt_addr`  in  RA_W  source register numbers
- `id_rs_data`, `id_rt_data`  in  DATA_W  register-file read data
- `id_imm`  in  DATA_W  sign- or zero-extended immediate
- `id_alu_src`  in  1  1 selects the immediate as ALU B; 0 selects rt
- `id_rd_addr`  in  RA_W  destination register number
- `id_reg_write`  in  1  instruction writes the register file
- `id_mem_read`  in  1  instruction is a load
- `exmem_reg_write`  in  1  EX/MEM instruction writes back
- `exmem_rd_addr`  in  RA_W  EX/MEM destination register
- `exmem_result`  in  DATA_W  EX/MEM ALU result
- `memwb_reg_write`  in  1  MEM/WB instruction writes back
- `memwb_rd_addr`  in  RA_W  MEM/WB destination register
- `memwb_result`  in  DATA_W  MEM/WB write-back value
- `alu_op`  out  4  registered op code, to the ALU's `AluOp`
- `alu_a`  out  DATA_W  forwarded rs, to the ALU's `A`
- `alu_b`  out  DATA_W  immediate or forwarded rt, to the ALU's `B`
- `ex_store_data`  out  DATA_W  forwarded rt, always (store data)
- `ex_valid`, `ex_reg_write`, `ex_mem_read`  out  1  registered control bits
- `ex_rd_addr`  out  RA_W  registered destination register
- `load_use_stall`  out  1  combinational; the upstream stages must hold PC and IF/ID

## Operation
- **ID/EX register contents:** valid, alu_op, rs/rt addresses, rs/rt data, imm, alu_src, rd_addr, reg_write, mem_read.
- **Update priority on each rising edge:** `reset` > `flush` > `stall` > `load_use_stall` > normal load.
  - `reset` or `flush`: every field becomes 0. This is a bubble: valid=0, reg_write=0, mem_read=0, rd=0, addresses=0, data=0.
  - `stall`: hold all fields.
  - `load_use_stall`: load a bubble. The decode-stage instruction is re-presented next cycle.
  - Otherwise: load all `id_*` fields.
- **Load-use detection:**
  - `load_use_stall` = `ex_valid & ex_mem_read & (ex_rd_addr != 0) & id_valid & ((ex_rd_addr == id_rs_addr) | (ex_rd_addr == id_rt_addr))`.
  - rt is compared even when `id_alu_src`=1, which is conservative.
- **Forwarding** (combinational, on the registered source addresses; applied separately for rs and rt):
  - The source address is 0: use the registered data. Register 0 is never forwarded.
  - Else if `exmem_reg_write` and `exmem_rd_addr` matches: use `exmem_result`.
  - Else if `memwb_reg_write` and `memwb_rd_addr` matches: use `memwb_result`.
  - Else: use the registered data.
  - EX/MEM always wins over MEM/WB.
- **Outputs:** `alu_a` = forwarded rs; `ex_store_data` = forwarded rt; `alu_b` = `imm` if alu_src else forwarded rt.
- **Bubbles:** a bubble's outputs follow the zero-field rule above, so with no forwarding match `alu_a`/`alu_b` = 0. Downstream ignores bubbles via `ex_valid`/`ex_reg_write`.
- **Arithmetic:** none is performed; all paths are full DATA_W with no truncation.

## Timing
- Latency is one cycle from `id_*` to the registered outputs. Forwarded `alu_a`/`alu_b` are valid in the same cycle as the EX/MEM and MEM/WB inputs, with no added register.
- **After reset:** all registered outputs are 0 and `load_use_stall`=0. `alu_a`=`alu_b`=`ex_store_data`=0 because the source addresses are 0.
- **Load-use:** `load_use_stall` is high for exactly one cycle per load-use pair. In the next cycle the load has moved to EX/MEM, so the stall condition is false and the dependent instruction loads.
- **Simultaneous events:**
  - `flush` with `stall`: flush wins.
  - `flush` with `load_use_stall`: a bubble either way.
  - `stall` with `load_use_stall`: hold. `load_use_stall` stays asserted while the hold persists.
- **Reset mid-operation:** the in-flight instruction is discarded and the stage holds a bubble on the next cycle.

## Test plan
- **Reset:** assert `reset` 2 cycles with random `id_*` -> all outputs 0, `ex_valid`=0, `load_use_stall`=0.
- **Passthrough:** load rs=3/data 0x10, rt=4/data 0x20, alu_op=4'b0010, alu_src=0, no forwarding -> next cycle `alu_a`=0x10, `alu_b`=0x20, `alu_op`=0010. Repeat with alu_src=1, imm=0xFFFFFFFC -> `alu_b`=0xFFFFFFFC, `ex_store_data`=0x20.
- **Forwarding priority:** registered rs=5; exmem (we=1, rd=5, 0xAAAA) and memwb (we=1, rd=5, 0xBBBB) -> `alu_a`=0xAAAA. Drop exmem we -> 0xBBBB. Set rd=0 on both with rs=0 -> registered data.
- **Load-use:** EX holds a load with rd=7; ID has rs=7 -> `load_use_stall`=1 for one cycle and the next ID/EX is a bubble. The cycle after, the instruction loads and rs forwards from MEM/WB when the load value is presented there.
- **Control priority:** `flush`=1 with `stall`=1 -> bubble. `stall`=1 alone for 3 cycles -> outputs constant. Releasing the stall loads the current `id_*`.
- **Mid-stream reset:** assert `reset` while EX holds a valid reg_write instruction -> next cycle `ex_valid`=0, `ex_reg_write`=0.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ex_operand_stage
//
// ID/EX pipeline register with operand forwarding, feeding the ALU.
// Each cycle it latches one decoded instruction. RAW hazards are resolved by
// forwarding from EX/MEM (highest priority) and MEM/WB. A load-use hazard
// inserts a one-cycle bubble.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   stall, flush          global hold / redirect bubble
//   id_*                  decoded instruction from the decode stage
//   exmem_*, memwb_*      write-back info from later stages, used for forwarding
//   alu_op, alu_a, alu_b  ALU operands (a/b forwarded combinationally)
//   ex_store_data         forwarded rt, used as store data
//   ex_valid, ex_reg_write, ex_mem_read, ex_rd_addr   registered control
//   load_use_stall        combinational; upstream must hold PC and IF/ID

module ex_operand_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RA_W   = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [3:0]        id_alu_op,
   input  logic [RA_W-1:0]   id_rs_addr,
   input  logic [RA_W-1:0]   id_rt_addr,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              id_alu_src,
   input  logic [RA_W-1:0]   id_rd_addr,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              exmem_reg_write,
   input  logic [RA_W-1:0]   exmem_rd_addr,
   input  logic [DATA_W-1:0] exmem_result,
   input  logic              memwb_reg_write,
   input  logic [RA_W-1:0]   memwb_rd_addr,
   input  logic [DATA_W-1:0] memwb_result,
   output logic [3:0]        alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [DATA_W-1:0] ex_store_data,
   output logic              ex_valid,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic [RA_W-1:0]   ex_rd_addr,
   output logic              load_use_stall
);

   // ID/EX register fields
   logic              valid_q;
   logic [3:0]        alu_op_q;
   logic [RA_W-1:0]   rs_addr_q;
   logic [RA_W-1:0]   rt_addr_q;
   logic [DATA_W-1:0] rs_data_q;
   logic [DATA_W-1:0] rt_data_q;
   logic [DATA_W-1:0] imm_q;
   logic              alu_src_q;
   logic [RA_W-1:0]   rd_addr_q;
   logic              reg_write_q;
   logic              mem_read_q;

   logic [DATA_W-1:0] fwd_rs;
   logic [DATA_W-1:0] fwd_rt;

   // rt is compared even for immediate-form instructions; harmless extra stall.
   assign load_use_stall = valid_q & mem_read_q & (rd_addr_q != '0) & id_valid &
                           ((rd_addr_q == id_rs_addr) | (rd_addr_q == id_rt_addr));

   always_ff @(posedge clk) begin
      if (reset || flush || (!stall && load_use_stall)) begin
         valid_q     <= 1'b0;
         alu_op_q    <= '0;
         rs_addr_q   <= '0;
         rt_addr_q   <= '0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         imm_q       <= '0;
         alu_src_q   <= 1'b0;
         rd_addr_q   <= '0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
      end else if (!stall) begin
         valid_q     <= id_valid;
         alu_op_q    <= id_alu_op;
         rs_addr_q   <= id_rs_addr;
         rt_addr_q   <= id_rt_addr;
         rs_data_q   <= id_rs_data;
         rt_data_q   <= id_rt_data;
         imm_q       <= id_imm;
         alu_src_q   <= id_alu_src;
         rd_addr_q   <= id_rd_addr;
         reg_write_q <= id_reg_write;
         mem_read_q  <= id_mem_read;
      end
   end

   // Forwarding: register 0 is never forwarded; EX/MEM beats MEM/WB.
   always_comb begin
      fwd_rs = rs_data_q;
      if (rs_addr_q != '0) begin
         if (exmem_reg_write && (exmem_rd_addr == rs_addr_q)) begin
            fwd_rs = exmem_result;
         end else if (memwb_reg_write && (memwb_rd_addr == rs_addr_q)) begin
            fwd_rs = memwb_result;
         end
      end
   end

   always_comb begin
      fwd_rt = rt_data_q;
      if (rt_addr_q != '0) begin
         if (exmem_reg_write && (exmem_rd_addr == rt_addr_q)) begin
            fwd_rt = exmem_result;
         end else if (memwb_reg_write && (memwb_rd_addr == rt_addr_q)) begin
            fwd_rt = memwb_result;
         end
      end
   end

   assign alu_op        = alu_op_q;
   assign alu_a         = fwd_rs;
   assign alu_b         = alu_src_q ? imm_q : fwd_rt;
   assign ex_store_data = fwd_rt;
   assign ex_valid      = valid_q;
   assign ex_reg_write  = reg_write_q;
   assign ex_mem_read   = mem_read_q;
   assign ex_rd_addr    = rd_addr_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

   logic        clk = 1'b0;
   logic        reset, stall, flush;
   logic        id_valid, id_alu_src, id_reg_write, id_mem_read;
   logic [3:0]  id_alu_op;
   logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic        exmem_reg_write, memwb_reg_write;
   logic [4:0]  exmem_rd_addr, memwb_rd_addr;
   logic [31:0] exmem_result, memwb_result;

   logic [3:0]  alu_op;
   logic [31:0] alu_a, alu_b, ex_store_data;
   logic        ex_valid, ex_reg_write, ex_mem_read, load_use_stall;
   logic [4:0]  ex_rd_addr;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ex_operand_stage dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .flush          (flush),
      .id_valid       (id_valid),
      .id_alu_op      (id_alu_op),
      .id_rs_addr     (id_rs_addr),
      .id_rt_addr     (id_rt_addr),
      .id_rs_data     (id_rs_data),
      .id_rt_data     (id_rt_data),
      .id_imm         (id_imm),
      .id_alu_src     (id_alu_src),
      .id_rd_addr     (id_rd_addr),
      .id_reg_write   (id_reg_write),
      .id_mem_read    (id_mem_read),
      .exmem_reg_write(exmem_reg_write),
      .exmem_rd_addr  (exmem_rd_addr),
      .exmem_result   (exmem_result),
      .memwb_reg_write(memwb_reg_write),
      .memwb_rd_addr  (memwb_rd_addr),
      .memwb_result   (memwb_result),
      .alu_op         (alu_op),
      .alu_a          (alu_a),
      .alu_b          (alu_b),
      .ex_store_data  (ex_store_data),
      .ex_valid       (ex_valid),
      .ex_reg_write   (ex_reg_write),
      .ex_mem_read    (ex_mem_read),
      .ex_rd_addr     (ex_rd_addr),
      .load_use_stall (load_use_stall)
   );

   // Reference model: the instruction currently sitting in EX.
   typedef struct {
      logic        valid;
      logic [3:0]  op;
      logic [4:0]  rs, rt, rd;
      logic [31:0] rs_data, rt_data, imm;
      logic        src, we, ld;
   } instr_t;

   instr_t ex_m;
   instr_t bubble = '{valid: 1'b0, op: 4'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0,
                      rs_data: 32'd0, rt_data: 32'd0, imm: 32'd0,
                      src: 1'b0, we: 1'b0, ld: 1'b0};

   function automatic logic model_hazard();
      return ex_m.valid && ex_m.ld && ex_m.rd != 0 && id_valid &&
             (ex_m.rd == id_rs_addr || ex_m.rd == id_rt_addr);
   endfunction

   function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] d);
      if (a == 0) return d;
      if (exmem_reg_write && exmem_rd_addr == a) return exmem_result;
      if (memwb_reg_write && memwb_rd_addr == a) return memwb_result;
      return d;
   endfunction

   function automatic instr_t decode_instr();
      instr_t i;
      i.valid = id_valid;     i.op = id_alu_op;
      i.rs = id_rs_addr;      i.rt = id_rt_addr;      i.rd = id_rd_addr;
      i.rs_data = id_rs_data; i.rt_data = id_rt_data; i.imm = id_imm;
      i.src = id_alu_src;     i.we = id_reg_write;    i.ld = id_mem_read;
      return i;
   endfunction

   function automatic instr_t model_next();
      if (reset || flush) return bubble;
      if (stall) return ex_m;
      if (model_hazard()) return bubble;
      return decode_instr();
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [31:0] rt_v;
      rt_v = operand(ex_m.rt, ex_m.rt_data);
      check({tag, ".op"}, 32'(alu_op), 32'(ex_m.op));
      check({tag, ".a"}, alu_a, operand(ex_m.rs, ex_m.rs_data));
      check({tag, ".b"}, alu_b, ex_m.src ? ex_m.imm : rt_v);
      check({tag, ".st"}, ex_store_data, rt_v);
      check({tag, ".valid"}, 32'(ex_valid), 32'(ex_m.valid));
      check({tag, ".we"}, 32'(ex_reg_write), 32'(ex_m.we));
      check({tag, ".ld"}, 32'(ex_mem_read), 32'(ex_m.ld));
      check({tag, ".rd"}, 32'(ex_rd_addr), 32'(ex_m.rd));
      check({tag, ".lus"}, 32'(load_use_stall), 32'(model_hazard()));
   endtask

   // Called just after a falling edge with inputs set: check, then clock once.
   task automatic cycle(input string tag);
      instr_t nxt;
      #1;
      check_all(tag);
      nxt = model_next();
      @(posedge clk);
      ex_m = nxt;
      @(negedge clk);
   endtask

   task automatic rand_id();
      id_valid     = 1'($urandom);
      id_alu_op    = 4'($urandom);
      id_rs_addr   = 5'($urandom_range(0, 7));
      id_rt_addr   = 5'($urandom_range(0, 7));
      id_rd_addr   = 5'($urandom_range(0, 7));
      id_rs_data   = $urandom;
      id_rt_data   = $urandom;
      id_imm       = $urandom;
      id_alu_src   = 1'($urandom);
      id_reg_write = 1'($urandom);
      id_mem_read  = 1'($urandom);
   endtask

   task automatic rand_fwd();
      exmem_reg_write = 1'($urandom);
      exmem_rd_addr   = 5'($urandom_range(0, 7));
      exmem_result    = $urandom;
      memwb_reg_write = 1'($urandom);
      memwb_rd_addr   = 5'($urandom_range(0, 7));
      memwb_result    = $urandom;
   endtask

   task automatic set_id(input logic v, input logic [3:0] op, input logic [4:0] rs,
                         input logic [31:0] rsd, input logic [4:0] rt, input logic [31:0] rtd,
                         input logic [31:0] imm, input logic src, input logic [4:0] rd,
                         input logic we, input logic ld);
      id_valid = v; id_alu_op = op; id_rs_addr = rs; id_rs_data = rsd;
      id_rt_addr = rt; id_rt_data = rtd; id_imm = imm; id_alu_src = src;
      id_rd_addr = rd; id_reg_write = we; id_mem_read = ld;
   endtask

   task automatic no_fwd();
      exmem_reg_write = 0; exmem_rd_addr = 0; exmem_result = 32'h0;
      memwb_reg_write = 0; memwb_rd_addr = 0; memwb_result = 32'h0;
   endtask

   initial begin
      // Reset for two cycles with random decode inputs
      reset = 1; stall = 0; flush = 0;
      rand_id();
      rand_fwd();
      repeat (2) @(posedge clk);
      @(negedge clk);
      ex_m  = bubble;
      reset = 0;
      id_valid = 0;
      no_fwd();
      #1;
      check("rst.valid", 32'(ex_valid), 32'd0);
      check("rst.a", alu_a, 32'd0);
      check("rst.b", alu_b, 32'd0);
      check("rst.lus", 32'(load_use_stall), 32'd0);
      cycle("rst");

      // Passthrough, register operand then immediate operand
      set_id(1, 4'b0010, 5'd3, 32'h10, 5'd4, 32'h20, 32'h0, 0, 5'd9, 1, 0);
      cycle("pt_load");
      id_valid = 0;
      #1;
      check("pt.a", alu_a, 32'h10);
      check("pt.b", alu_b, 32'h20);
      check("pt.op", 32'(alu_op), 32'h2);
      cycle("pt_chk");
      set_id(1, 4'b0010, 5'd3, 32'h10, 5'd4, 32'h20, 32'hFFFF_FFFC, 1, 5'd9, 1, 0);
      cycle("pti_load");
      id_valid = 0;
      #1;
      check("pti.b", alu_b, 32'hFFFF_FFFC);
      check("pti.st", ex_store_data, 32'h20);

      // Forwarding priority
      set_id(1, 4'h0, 5'd5, 32'h55, 5'd6, 32'h66, 32'h0, 0, 5'd1, 1, 0);
      cycle("fw_load");
      id_valid = 0;
      exmem_reg_write = 1; exmem_rd_addr = 5'd5; exmem_result = 32'hAAAA;
      memwb_reg_write = 1; memwb_rd_addr = 5'd5; memwb_result = 32'hBBBB;
      #1;
      check("fw.exmem", alu_a, 32'hAAAA);
      exmem_reg_write = 0;
      #1;
      check("fw.memwb", alu_a, 32'hBBBB);
      cycle("fw_mw");
      set_id(1, 4'h0, 5'd0, 32'h77, 5'd0, 32'h88, 32'h0, 0, 5'd1, 1, 0);
      exmem_reg_write = 1; exmem_rd_addr = 5'd0;
      memwb_reg_write = 1; memwb_rd_addr = 5'd0;
      cycle("fw0_load");
      id_valid = 0;
      #1;
      check("fw.r0", alu_a, 32'h77);
      cycle("fw0");
      no_fwd();

      // Load-use: load to r7, then a consumer of r7
      set_id(1, 4'h0, 5'd1, 32'h0, 5'd2, 32'h0, 32'h4, 1, 5'd7, 1, 1);
      cycle("lu_load");
      set_id(1, 4'h3, 5'd7, 32'h1234, 5'd2, 32'h5, 32'h0, 0, 5'd8, 1, 0);
      #1;
      check("lu.stall", 32'(load_use_stall), 32'd1);
      cycle("lu_hz");
      check("lu.bubble", 32'(ex_valid), 32'd0);
      check("lu.clear", 32'(load_use_stall), 32'd0);
      exmem_reg_write = 1; exmem_rd_addr = 5'd7; exmem_result = 32'hC0DE;
      cycle("lu_reissue");
      exmem_reg_write = 0;
      memwb_reg_write = 1; memwb_rd_addr = 5'd7; memwb_result = 32'hDEAD;
      id_valid = 0;
      #1;
      check("lu.fwd", alu_a, 32'hDEAD);
      check("lu.valid", 32'(ex_valid), 32'd1);
      cycle("lu_fwd");
      no_fwd();

      // Control priority: flush beats stall
      set_id(1, 4'h5, 5'd1, 32'h11, 5'd2, 32'h22, 32'h0, 0, 5'd3, 1, 0);
      cycle("cp_load");
      flush = 1; stall = 1;
      cycle("cp_flush");
      flush = 0; stall = 0;
      check("cp.flush", 32'(ex_valid), 32'd0);
      // Stall holds for three cycles
      set_id(1, 4'h9, 5'd1, 32'h99, 5'd2, 32'h22, 32'h0, 0, 5'd3, 1, 0);
      cycle("st_load");
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         rand_id();
         id_valid = 0;
         cycle("st_hold");
         check("st.op", 32'(alu_op), 32'h9);
         check("st.a", alu_a, 32'h99);
      end
      stall = 0;
      set_id(1, 4'hA, 5'd1, 32'hABC, 5'd2, 32'h22, 32'h0, 0, 5'd3, 1, 0);
      cycle("st_release");
      check("st.rel", 32'(alu_op), 32'hA);

      // Mid-stream reset
      reset = 1;
      cycle("mr");
      reset = 0;
      check("mr.valid", 32'(ex_valid), 32'd0);
      check("mr.we", 32'(ex_reg_write), 32'd0);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         rand_id();
         rand_fwd();
         stall = ($urandom_range(0, 9) == 0);
         flush = ($urandom_range(0, 9) == 0);
         reset = ($urandom_range(0, 29) == 0);
         cycle("rnd");
      end
      reset = 0; stall = 0; flush = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
